avalon_mm_csr_bank: RTL and testbench



---
 rtl/avalon_mm_csr_bank_if.sv | 38 +++
 rtl/avalon_mm_csr_bank.sv | 131 +++++++++++++
 tb/tb_avalon_mm_csr_bank.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_csr_bank_if.sv
// Avalon-MM slave bus bundle for the CSR bank.
// The optional response field exists only when AVMM_RESP_EN is defined.
interface avalon_mm_csr_bank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avalon_mm_addr;
  logic                avalon_mm_write;
  logic                avalon_mm_read;
  logic [DATA_W/8-1:0] avalon_mm_byteenable;
  logic [DATA_W-1:0]   avalon_mm_write_data;
  logic [DATA_W-1:0]   avalon_mm_read_data;
  logic                avalon_mm_rd_valid;
`ifdef AVMM_RESP_EN
  logic [1:0]          avalon_mm_response;
`endif

  // Handshake: there is no waitrequest, so read/write are accepted in the
  // cycle they are high; rd_valid is high exactly one cycle after each
  // accepted read and carries read_data (and response) for that read.
  modport master (
    output avalon_mm_addr, avalon_mm_write, avalon_mm_read,
    output avalon_mm_byteenable, avalon_mm_write_data,
`ifdef AVMM_RESP_EN
    input  avalon_mm_response,
`endif
    input  avalon_mm_read_data, avalon_mm_rd_valid
  );

  modport slave (
    input  avalon_mm_addr, avalon_mm_write, avalon_mm_read,
    input  avalon_mm_byteenable, avalon_mm_write_data,
`ifdef AVMM_RESP_EN
    output avalon_mm_response,
`endif
    output avalon_mm_read_data, avalon_mm_rd_valid
  );
endinterface

// File: rtl/avalon_mm_csr_bank.sv
// Avalon-MM CSR bank: control words, synchronised/sticky status words, ID register.
// Optional AVMM_RESP_EN adds a read response and an unmapped-write error pulse.
module avalon_mm_csr_bank #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 32,
  parameter int                N_CTRL       = 4,
  parameter int                N_STAT       = 2,
  parameter logic [ADDR_W-1:0] ID_ADDR      = 16'h0010,
  parameter logic [DATA_W-1:0] ID_VALUE     = 32'hFF0FF423,
  parameter logic [ADDR_W-1:0] CTRL_BASE    = 16'h0050,
  parameter logic [ADDR_W-1:0] STAT_BASE    = 16'h00C0,
  parameter logic [DATA_W-1:0] CTRL_RST_VAL = '0,
  parameter int                SYNC_STAGES  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  avalon_mm_csr_bank_if.slave      bus,
  output logic [N_CTRL*DATA_W-1:0] ctrl_q,
  output logic [N_CTRL-1:0]        ctrl_wr_pulse,
`ifdef AVMM_RESP_EN
  output logic                     err_unmapped_wr,
`endif
  input  logic [N_STAT*DATA_W-1:0] stat_in
);

  localparam int NB = DATA_W / 8;
  localparam int SW = N_STAT * DATA_W;

  logic [DATA_W-1:0]              be_mask;
  logic [N_CTRL-1:0]              ctrl_hit;
  logic [N_STAT-1:0]              live_hit;
  logic [N_STAT-1:0]              stky_hit;
  logic                           id_hit;
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [SW-1:0]                  stat_sync;
  logic [SW-1:0]                  stat_prev;
  logic [SW-1:0]                  sticky_q;
  logic [SW-1:0]                  sticky_clr;
  logic [DATA_W-1:0]              rd_mux;

  assign stat_sync = sync_q[SYNC_STAGES-1];

  // Exact-match decode of every register address.
  always_comb begin
    id_hit = (bus.avalon_mm_addr == ID_ADDR);
    for (int i = 0; i < N_CTRL; i++)
      ctrl_hit[i] = (bus.avalon_mm_addr == ADDR_W'(CTRL_BASE + ADDR_W'(4 * i)));
    for (int j = 0; j < N_STAT; j++) begin
      live_hit[j] = (bus.avalon_mm_addr == ADDR_W'(STAT_BASE + ADDR_W'(8 * j)));
      stky_hit[j] = (bus.avalon_mm_addr == ADDR_W'(STAT_BASE + ADDR_W'(8 * j + 4)));
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++)
      be_mask[b*8 +: 8] = {8{bus.avalon_mm_byteenable[b]}};
  end

  always_comb begin
    sticky_clr = '0;
    for (int j = 0; j < N_STAT; j++)
      if (bus.avalon_mm_write && stky_hit[j])
        sticky_clr[j*DATA_W +: DATA_W] = bus.avalon_mm_write_data & be_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q        <= {N_CTRL{CTRL_RST_VAL}};
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= bus.avalon_mm_write ? ctrl_hit : '0;
      for (int i = 0; i < N_CTRL; i++)
        if (bus.avalon_mm_write && ctrl_hit[i])
          ctrl_q[i*DATA_W +: DATA_W] <= (ctrl_q[i*DATA_W +: DATA_W] & ~be_mask) |
                                        (bus.avalon_mm_write_data & be_mask);
    end
  end

  // The set term is ORed in after the clear so a coincident edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      stat_prev <= '0;
      sticky_q  <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], stat_in};
      stat_prev <= stat_sync;
      sticky_q  <= (sticky_q & ~sticky_clr) | (stat_sync & ~stat_prev);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (id_hit) rd_mux = ID_VALUE;
    for (int i = 0; i < N_CTRL; i++)
      if (ctrl_hit[i]) rd_mux = ctrl_q[i*DATA_W +: DATA_W];
    for (int j = 0; j < N_STAT; j++) begin
      if (live_hit[j]) rd_mux = stat_sync[j*DATA_W +: DATA_W];
      if (stky_hit[j]) rd_mux = sticky_q[j*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.avalon_mm_rd_valid  <= 1'b0;
      bus.avalon_mm_read_data <= '0;
    end else begin
      bus.avalon_mm_rd_valid <= bus.avalon_mm_read;
      if (bus.avalon_mm_read) bus.avalon_mm_read_data <= rd_mux;
    end
  end

`ifdef AVMM_RESP_EN
  logic rd_mapped;
  logic wr_mapped;

  assign rd_mapped = id_hit | (|ctrl_hit) | (|live_hit) | (|stky_hit);
  assign wr_mapped = (|ctrl_hit) | (|stky_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.avalon_mm_response <= 2'b00;
      err_unmapped_wr        <= 1'b0;
    end else begin
      if (bus.avalon_mm_read) bus.avalon_mm_response <= rd_mapped ? 2'b00 : 2'b10;
      err_unmapped_wr <= bus.avalon_mm_write & ~wr_mapped;
    end
  end
`endif

endmodule

// File: tb/tb_avalon_mm_csr_bank.sv
// Self-checking bench for avalon_mm_csr_bank: directed vector table, status
// corner sequences, randomized traffic against a register-map model, mid-access reset.
module tb_avalon_mm_csr_bank;
  localparam int          SS        = 2;
  localparam int          N_CTRL    = 4;
  localparam int          N_STAT    = 2;
  localparam logic [15:0] ID_ADDR   = 16'h0010;
  localparam logic [31:0] ID_VALUE  = 32'hFF0FF423;
  localparam logic [15:0] CTRL_BASE = 16'h0050;
  localparam logic [15:0] STAT_BASE = 16'h00C0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [127:0] ctrl_q;
  logic [3:0]  ctrl_wr_pulse;
  logic [63:0] stat_in = '0;
`ifdef AVMM_RESP_EN
  logic        err_unmapped_wr;
`endif

  int checks = 0;
  int failures = 0;

  avalon_mm_csr_bank_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  avalon_mm_csr_bank #(
    .ADDR_W(16), .DATA_W(32), .N_CTRL(N_CTRL), .N_STAT(N_STAT),
    .ID_ADDR(ID_ADDR), .ID_VALUE(ID_VALUE), .CTRL_BASE(CTRL_BASE),
    .STAT_BASE(STAT_BASE), .CTRL_RST_VAL(32'h0), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .ctrl_q(ctrl_q),
    .ctrl_wr_pulse(ctrl_wr_pulse),
`ifdef AVMM_RESP_EN
    .err_unmapped_wr(err_unmapped_wr),
`endif
    .stat_in(stat_in)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: register contents and a delay line of sampled stat_in
  logic [31:0] ctrl_m [N_CTRL];
  logic [31:0] sticky_m [N_STAT];
  logic [63:0] hist [$];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  task automatic model_reset();
    for (int i = 0; i < N_CTRL; i++) ctrl_m[i] = '0;
    for (int j = 0; j < N_STAT; j++) sticky_m[j] = '0;
    hist.delete();
    for (int k = 0; k < SS + 1; k++) hist.push_back('0);
    exp_q.delete();
    last_rd = '0;
  endtask

  function automatic logic [15:0] ctrl_addr(int i);
    return 16'(CTRL_BASE + 16'(4 * i));
  endfunction
  function automatic logic [15:0] live_addr(int j);
    return 16'(STAT_BASE + 16'(8 * j));
  endfunction
  function automatic logic [15:0] stky_addr(int j);
    return 16'(STAT_BASE + 16'(8 * j + 4));
  endfunction

  function automatic logic [31:0] model_read(logic [15:0] a);
    logic [63:0] live;
    logic [31:0] v;
    live = hist[SS-1];
    v = '0;
    if (a == ID_ADDR) v = ID_VALUE;
    for (int i = 0; i < N_CTRL; i++) if (a == ctrl_addr(i)) v = ctrl_m[i];
    for (int j = 0; j < N_STAT; j++) begin
      if (a == live_addr(j)) v = live[j*32 +: 32];
      if (a == stky_addr(j)) v = sticky_m[j];
    end
    return v;
  endfunction

  function automatic logic model_mapped(logic [15:0] a);
    logic m;
    m = (a == ID_ADDR);
    for (int i = 0; i < N_CTRL; i++) if (a == ctrl_addr(i)) m = 1'b1;
    for (int j = 0; j < N_STAT; j++) if (a == live_addr(j) || a == stky_addr(j)) m = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] pack_ctrl();
    logic [127:0] p;
    for (int i = 0; i < N_CTRL; i++) p[i*32 +: 32] = ctrl_m[i];
    return p;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(logic w, logic r, logic [15:0] a, logic [3:0] be, logic [31:0] wd);
    bus.avalon_mm_write      = w;
    bus.avalon_mm_read       = r;
    bus.avalon_mm_addr       = a;
    bus.avalon_mm_byteenable = be;
    bus.avalon_mm_write_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  // One clock: predict from the model, advance, compare all outputs.
  task automatic step();
    logic [15:0] a;
    logic        w, r, mapped, exp_err;
    logic [31:0] wd, m, clr, rv;
    logic [3:0]  be, exp_pulse;
    logic [63:0] ss, sp;
    a = bus.avalon_mm_addr; w = bus.avalon_mm_write; r = bus.avalon_mm_read;
    be = bus.avalon_mm_byteenable; wd = bus.avalon_mm_write_data;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    if (r) exp_q.push_back(model_read(a));
    mapped = model_mapped(a);
    exp_pulse = '0;
    exp_err = w;
    for (int i = 0; i < N_CTRL; i++)
      if (w && a == ctrl_addr(i)) begin
        exp_pulse[i] = 1'b1;
        exp_err = 1'b0;
        ctrl_m[i] = (ctrl_m[i] & ~m) | (wd & m);
      end
    ss = hist[SS-1];
    sp = hist[SS];
    for (int j = 0; j < N_STAT; j++) begin
      clr = '0;
      if (w && a == stky_addr(j)) begin
        clr = wd & m;
        exp_err = 1'b0;
      end
      sticky_m[j] = (sticky_m[j] & ~clr) | (ss[j*32 +: 32] & ~sp[j*32 +: 32]);
    end
    hist.push_front(stat_in);
    void'(hist.pop_back());
    @(posedge clk); #1;
    check("rd_valid", 128'(bus.avalon_mm_rd_valid), 128'(r));
    if (bus.avalon_mm_rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", 128'(1), 128'(0));
      else begin
        rv = exp_q.pop_front();
        check("read_data", 128'(bus.avalon_mm_read_data), 128'(rv));
        last_rd = rv;
      end
`ifdef AVMM_RESP_EN
      check("response", 128'(bus.avalon_mm_response), mapped ? 128'(0) : 128'(2));
`endif
    end else begin
      check("read_hold", 128'(bus.avalon_mm_read_data), 128'(last_rd));
    end
    check("ctrl_wr_pulse", 128'(ctrl_wr_pulse), 128'(exp_pulse));
    check("ctrl_q", ctrl_q, pack_ctrl());
`ifdef AVMM_RESP_EN
    check("err_unmapped_wr", 128'(err_unmapped_wr), 128'(exp_err));
`else
    if (mapped && exp_err) begin end
`endif
  endtask

  task automatic read_expect(string name, logic [15:0] a, logic [31:0] exp);
    drive(1'b0, 1'b1, a, 4'h0, 32'h0);
    step();
    check(name, 128'(bus.avalon_mm_read_data), 128'(exp));
    idle();
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, CTRL_BASE,        4'h0, 32'h0,        32'h0,        4'b0000};
    vecs[1]  = '{1'b0, 1'b1, ID_ADDR,          4'h0, 32'h0,        32'hFF0FF423, 4'b0000};
    vecs[2]  = '{1'b0, 1'b1, 16'h0004,         4'h0, 32'h0,        32'h0,        4'b0000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0054,         4'b0101, 32'hDEADBEEF, 32'h0,     4'b0010};
    vecs[4]  = '{1'b0, 1'b1, 16'h0054,         4'h0, 32'h0,        32'h00AD00EF, 4'b0000};
    vecs[5]  = '{1'b1, 1'b0, CTRL_BASE,        4'hF, 32'h11,       32'h0,        4'b0001};
    vecs[6]  = '{1'b1, 1'b1, CTRL_BASE,        4'hF, 32'h22,       32'h11,       4'b0001};
    vecs[7]  = '{1'b0, 1'b1, CTRL_BASE,        4'h0, 32'h0,        32'h22,       4'b0000};
    vecs[8]  = '{1'b1, 1'b0, ID_ADDR,          4'hF, 32'h12345678, 32'h0,        4'b0000};
    vecs[9]  = '{1'b0, 1'b1, ID_ADDR,          4'h0, 32'h0,        32'hFF0FF423, 4'b0000};
    vecs[10] = '{1'b1, 1'b0, 16'h005C,         4'h0, 32'hFFFFFFFF, 32'h0,        4'b1000};
    vecs[11] = '{1'b0, 1'b1, 16'h005C,         4'h0, 32'h0,        32'h0,        4'b0000};
    vecs[12] = '{1'b0, 1'b1, 16'h0051,         4'h0, 32'h0,        32'h0,        4'b0000};

    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_valid", 128'(bus.avalon_mm_rd_valid), 128'(0));
    check("reset_read_data", 128'(bus.avalon_mm_read_data), 128'(0));
    check("reset_ctrl_q", ctrl_q, 128'(0));
    check("reset_pulse", 128'(ctrl_wr_pulse), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vector table
    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].be, vecs[v].wd);
      step();
      if (vecs[v].rd) check($sformatf("vec%0d_rd", v), 128'(bus.avalon_mm_read_data), 128'(vecs[v].exp_rd));
      check($sformatf("vec%0d_pulse", v), 128'(ctrl_wr_pulse), 128'(vecs[v].exp_pulse));
    end
    idle();
    step();
    check("pulse_single", 128'(ctrl_wr_pulse), 128'(0));

    // status: sync latency, sticky capture, hold, W1C
    stat_in = 64'h8;
    repeat (SS) step();
    read_expect("live_rise", STAT_BASE, 32'h8);
    read_expect("sticky_set", 16'h00C4, 32'h8);
    stat_in = 64'h0;
    repeat (4) step();
    read_expect("live_fall", STAT_BASE, 32'h0);
    read_expect("sticky_hold", 16'h00C4, 32'h8);
    drive(1'b1, 1'b0, 16'h00C4, 4'hF, 32'h8);
    step();
    idle();
    read_expect("sticky_w1c", 16'h00C4, 32'h0);

    // rising edge and W1C on the same edge: set wins
    stat_in = 64'h8;
    repeat (SS) step();
    drive(1'b1, 1'b0, 16'h00C4, 4'hF, 32'h8);
    step();
    idle();
    read_expect("sticky_set_wins", 16'h00C4, 32'h8);
    drive(1'b1, 1'b0, 16'h00C4, 4'hF, 32'h8);
    step();
    idle();
    read_expect("sticky_clr_level", 16'h00C4, 32'h0);
    stat_in = 64'h0;
    repeat (SS + 1) step();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] pool [13];
      pool = '{ID_ADDR, 16'h0050, 16'h0054, 16'h0058, 16'h005C, 16'h00C0, 16'h00C4,
               16'h00C8, 16'h00CC, 16'h0004, 16'h0100, 16'h0052, 16'h0060};
      if ($urandom_range(0, 3) == 0) stat_in = {$urandom, $urandom};
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            pool[$urandom_range(0, 12)], 4'($urandom_range(0, 15)), $urandom);
      step();
    end
    idle();
    step();

    // reset asserted with a read in flight
    drive(1'b0, 1'b1, ID_ADDR, 4'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rd_valid", 128'(bus.avalon_mm_rd_valid), 128'(0));
    check("midrst_read_data", 128'(bus.avalon_mm_read_data), 128'(0));
    check("midrst_ctrl_q", ctrl_q, 128'(0));
    check("midrst_pulse", 128'(ctrl_wr_pulse), 128'(0));
    @(posedge clk); #1;
    check("midrst_no_valid", 128'(bus.avalon_mm_rd_valid), 128'(0));
    idle();
    stat_in = '0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    read_expect("post_rst_id", ID_ADDR, ID_VALUE);
    read_expect("post_rst_ctrl", 16'h0054, 32'h0);
    read_expect("post_rst_sticky", 16'h00C4, 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
